// File: rtl/adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
// Holds default operand/chunk widths and the stage-count function.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic int stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit registered slice of the pipelined adder.
// Adds its chunk, forwards operands/partial sum, handles load/valid.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prev_valid,
  input  logic             prev_c,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_y,
  input  logic             next_load,
  output logic             load,
  output logic             valid,
  output logic             c,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int LO = K * CHUNK;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] y_nxt;

  assign sum = {1'b0, prev_a[LO +: CHUNK]}
             + {1'b0, prev_b[LO +: CHUNK]}
             + {{CHUNK{1'b0}}, prev_c};

  always_comb begin
    y_nxt = prev_y;
    y_nxt[LO +: CHUNK] = sum[CHUNK-1:0];
  end

  // A bubble here, or a slot freeing downstream, lets this slice advance.
  assign load = !valid | next_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      c     <= 1'b0;
      a     <= '0;
      b     <= '0;
      y     <= '0;
    end else if (load) begin
      valid <= prev_valid;
      c     <= sum[CHUNK];
      a     <= prev_a;
      b     <= prev_b;
      y     <= y_nxt;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// N = WIDTH/CHUNK stage ripple-carry adder with valid/ready flow control.
// Define PIPELINED_ADDER_SUB_EN to add the SUB port (A - B - Cin).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             SUB,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N = stages(WIDTH, CHUNK);

  logic sub;
`ifdef PIPELINED_ADDER_SUB_EN
  assign sub = SUB;
`else
  assign sub = 1'b0;
`endif

  logic [N:0]            v_s;
  logic [N:0]            c_s;
  logic [N:0][WIDTH-1:0] a_s;
  logic [N:0][WIDTH-1:0] b_s;
  logic [N:0][WIDTH-1:0] y_s;

  assign v_s[0] = in_valid;
  assign c_s[0] = Cin ^ sub;
  assign a_s[0] = A;
  assign b_s[0] = B ^ {WIDTH{sub}};
  assign y_s[0] = '0;

  for (genvar k = 0; k < N; k++) begin : g_stg
    logic ld;
    logic nl;
    if (k == N - 1) begin : g_last
      assign nl = out_ready;
    end else begin : g_mid
      assign nl = g_stg[k+1].ld;
    end
    adder_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .K    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .prev_valid(v_s[k]),
      .prev_c    (c_s[k]),
      .prev_a    (a_s[k]),
      .prev_b    (b_s[k]),
      .prev_y    (y_s[k]),
      .next_load (nl),
      .load      (ld),
      .valid     (v_s[k+1]),
      .c         (c_s[k+1]),
      .a         (a_s[k+1]),
      .b         (b_s[k+1]),
      .y         (y_s[k+1])
    );
  end

  assign in_ready  = g_stg[0].ld;
  assign out_valid = v_s[N];
  assign Y         = y_s[N];
  assign C         = c_s[N];

  // Operands leaving the last slice have no consumer.
  logic unused;
  assign unused = ^{a_s[N], b_s[N]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder (WIDTH=16, CHUNK=4): directed cases
// plus randomized traffic against a queue-based arithmetic model.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        in_valid, out_ready;
  logic        in_ready, c, out_valid;
  logic [15:0] y;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];

  logic        obs_valid, obs_ready, obs_c, acc;
  logic [15:0] obs_y;

  always #5 clk = ~clk;

  pipelined_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .Cin      (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .SUB      (sub),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Y        (y),
    .C        (c),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] x,
                                        input logic [15:0] z,
                                        input logic ci, input logic sb);
    int unsigned r;
    if (sb) r = x + (32'hFFFF - z) + (ci ? 0 : 1);
    else    r = x + z + ci;
    return r[16:0];
  endfunction

  // One cycle: drive at negedge, observe, account for transfers at next posedge.
  task automatic tick(input logic iv, input logic [15:0] xa,
                      input logic [15:0] xb, input logic ci,
                      input logic sb, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = xa;
    b         = xb;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_y     = y;
    obs_c     = c;
    acc       = iv && in_ready;
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious", {31'd0, obs_valid}, 32'd0);
      end else begin
        check("result", {15'd0, obs_c, obs_y}, {15'd0, exp_q[0]});
        if (ordy) void'(exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(model(xa, xb, ci, sb));
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      idle(1'b1);
      lat++;
    end while (!obs_valid && lat < 20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {16'd0, y}, 32'd0);
    check("rst_c", {31'd0, c}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int lat, n, cyc;
  logic [15:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    do_reset();

    // all-ones + 1 wraps across every chunk
    idle(1'b1);
    check("ready_after_rst", {31'd0, obs_ready}, 32'd1);
    tick(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_out(lat);
    check("wrap_lat", lat, 4);
    check("wrap_sum", {15'd0, obs_c, obs_y}, 32'h10000);

    // back-to-back inputs, one result per cycle
    tick(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check("b2b_0", {14'd0, obs_valid, obs_c, obs_y}, 32'h20002);
    idle(1'b1);
    check("b2b_1", {14'd0, obs_valid, obs_c, obs_y}, 32'h20004);
    idle(1'b1);
    check("b2b_2", {14'd0, obs_valid, obs_c, obs_y}, 32'h30000);
    idle(1'b1);
    check("b2b_3", {14'd0, obs_valid, obs_c, obs_y}, 32'h25556);

    // backpressure: fill, hold, then drain with overlap
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 16'(i + 10), 16'(i * 3), 1'b0, 1'b0, 1'b0);
      if (acc) n++;
      if (i == 4) held = obs_y;
      if (i == 5) check("hold_y", {16'd0, obs_y}, {16'd0, held});
    end
    check("bp_accepted", n, 4);
    check("bp_in_ready", {31'd0, obs_ready}, 32'd0);
    tick(1'b1, 16'h0100, 16'h0200, 1'b1, 1'b0, 1'b1);
    check("full_overlap", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
    check("bp_drained", exp_q.size(), 0);

    // reset with items in flight
    tick(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0055, 16'h0066, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    do_reset();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (obs_valid) n++;
    end
    check("stale", n, 0);
    tick(1'b1, 16'd3, 16'd4, 1'b0, 1'b0, 1'b1);
    wait_out(lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_y", {16'd0, obs_y}, 32'd7);

`ifdef PIPELINED_ADDER_SUB_EN
    tick(1'b1, 16'd5, 16'd7, 1'b0, 1'b1, 1'b1);
    wait_out(lat);
    check("sub_neg", {15'd0, obs_c, obs_y}, 32'h0FFFE);
    tick(1'b1, 16'd7, 16'd5, 1'b0, 1'b1, 1'b1);
    wait_out(lat);
    check("sub_pos", {15'd0, obs_c, obs_y}, 32'h10002);
`endif

    // random traffic
    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      tick(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
           1'($urandom),
`ifdef PIPELINED_ADDER_SUB_EN
           1'($urandom),
`else
           1'b0,
`endif
           ($urandom % 4) != 0);
      if (acc) n++;
      cyc++;
    end
    check("rand_count", n, 10000);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
    check("rand_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
